// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream
// requesters; a grant covers one packet, capped at MAX_BURST bytes.
module uart_tx_arb #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [7:0]        tx_byte,
    output logic              tx_req,
    input  logic              tx_idle
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {ARB, TAKE, ISSUE, BUSY, WAIT} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [PW-1:0]   own, own_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            lastf, lastf_nxt;
    logic [7:0]      tx_byte_nxt;
    logic            tx_req_nxt;

    logic [7:0]      lane [NREQ];
    logic            found;
    logic [PW-1:0]   sel, cand;

    always_comb begin
        for (int i = 0; i < NREQ; i++) lane[i] = req_data[8*i +: 8];
    end

    // First valid requester searching upward from the one after the last owner.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        own_nxt     = own;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        lastf_nxt   = lastf;
        tx_byte_nxt = tx_byte;
        tx_req_nxt  = 1'b0;
        req_ready   = '0;
        unique case (state)
            ARB: begin
                if (tx_idle && found) begin
                    grant_nxt = NREQ'(1) << sel;
                    own_nxt   = sel;
                    cnt_nxt   = '0;
                    state_nxt = TAKE;
                end
            end
            TAKE: begin
                // Ready depends only on state and grant, never on valid.
                req_ready = grant;
                if (req_valid[own]) begin
                    tx_byte_nxt = lane[own];
                    tx_req_nxt  = 1'b1;
                    lastf_nxt   = req_last[own] | (cnt == CW'(MAX_BURST - 1));
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: state_nxt = BUSY;
            BUSY: begin
                if (!tx_idle) state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_idle) begin
                    if (lastf) begin
                        ptr_nxt   = own;
                        grant_nxt = '0;
                        state_nxt = ARB;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = TAKE;
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= ARB;
            grant   <= '0;
            own     <= '0;
            ptr     <= PW'(NREQ - 1);
            cnt     <= '0;
            lastf   <= 1'b0;
            tx_byte <= '0;
            tx_req  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            own     <= own_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            lastf   <= lastf_nxt;
            tx_byte <= tx_byte_nxt;
            tx_req  <= tx_req_nxt;
        end
    end

    assign busy = (state != ARB);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: per-requester packet queues feed the DUT,
// a monitor checks arbitration order, burst limits and bytes against a model.
module tb_uart_tx_arb;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } item_t;

    logic              clk       = 1'b0;
    logic              rst_      = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_last  = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready, grant;
    logic              busy, tx_req, tx_idle;
    logic [7:0]        tx_byte;

    uart_tx_arb #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .tx_byte   (tx_byte),
        .tx_req    (tx_req),
        .tx_idle   (tx_idle)
    );

    always #5 clk = ~clk;

    item_t src_q [NREQ][$];   // bytes still to be offered by each requester
    item_t exp_q [NREQ][$];   // bytes each requester expects to see transmitted
    int    grant_log[$];
    int    exp_log[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    rnd_mode = 1'b0;
    bit    block    = 1'b0;
    bit [NREQ-1:0] hold = '0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] g);
        for (int k = 0; k < NREQ; k++) if (g[k]) return k;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int k = 0; k < NREQ; k++)
            if (src_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(input int r, input logic [7:0] d, input bit l);
        item_t it;
        it.d = d;
        it.l = l;
        src_q[r].push_back(it);
        exp_q[r].push_back(it);
    endtask

    // Behavioural UART: goes busy the edge after it sees tx_req, stays busy a random frame.
    logic u_idle;
    int   u_cnt;
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            u_idle <= 1'b1;
            u_cnt  <= 0;
        end else if (u_idle) begin
            if (tx_req) begin
                u_idle <= 1'b0;
                u_cnt  <= $urandom_range(1, 6);
            end
        end else if (u_cnt == 0) begin
            u_idle <= 1'b1;
        end else begin
            u_cnt <= u_cnt - 1;
        end
    end
    assign tx_idle = u_idle && !block;

    // Requester driver: retire fired bytes, then present each queue head.
    logic [NREQ-1:0] drv_fire;
    initial begin
        forever begin
            @(negedge clk);
            drv_fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (drv_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = !hold[i] && (!rnd_mode || $urandom_range(0, 3) != 0);
                    req_data[8*i +: 8] = src_q[i][0].d;
                    req_last[i]        = src_q[i][0].l;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    logic [NREQ-1:0] p_grant, p_valid;
    logic            p_busy, p_idle, p_txreq;
    int              model_ptr, burst_cnt, cur_owner, exp_i;
    bit              end_due;
    logic [7:0]      last_byte;
    item_t           mon_it;

    always @(negedge clk) begin
        if (!rst_) begin
            model_ptr = NREQ - 1;
            burst_cnt = 0;
            cur_owner = 0;
            end_due   = 1'b0;
            last_byte = 8'h00;
            p_grant   = '0;
            p_valid   = '0;
            p_busy    = 1'b0;
            p_idle    = 1'b1;
            p_txreq   = 1'b0;
        end else begin
            if (p_grant != '0 && grant == '0) begin
                check(end_due, "release_at_end", burst_cnt, MAX_BURST);
                model_ptr = cur_owner;
                end_due   = 1'b0;
            end
            if (p_grant != '0 && grant != '0)
                check(grant == p_grant, "grant_stable", int'(grant), int'(p_grant));
            if (!p_busy && |p_valid) begin
                if (p_idle) begin
                    exp_i = rr_pick(model_ptr, p_valid);
                    check(grant == (NREQ'(1) << exp_i), "arb_grant", int'(grant), 1 << exp_i);
                    cur_owner = exp_i;
                    burst_cnt = 0;
                    end_due   = 1'b0;
                end else begin
                    check(grant == '0 && !busy, "arb_blocked", int'(grant), 0);
                end
            end
            if (p_grant == '0 && grant != '0) grant_log.push_back(idx_of(grant));
            check((req_ready & ~grant) == '0, "ready_in_grant", int'(req_ready), int'(grant));
            if (tx_req) begin
                check(!p_txreq, "txreq_one_cycle", int'(p_txreq), 0);
                check(tx_idle, "txreq_when_idle", int'(tx_idle), 1);
                check(!end_due, "no_byte_after_end", burst_cnt, MAX_BURST);
                if (exp_q[cur_owner].size() == 0) begin
                    check(1'b0, "unexpected_byte", int'(tx_byte), -1);
                end else begin
                    mon_it = exp_q[cur_owner].pop_front();
                    check(tx_byte == mon_it.d, "tx_byte", int'(tx_byte), int'(mon_it.d));
                    burst_cnt++;
                    end_due = mon_it.l || (burst_cnt == MAX_BURST);
                end
                last_byte = tx_byte;
            end else begin
                check(tx_byte == last_byte, "tx_byte_hold", int'(tx_byte), int'(last_byte));
            end
            p_grant = grant;
            p_valid = req_valid;
            p_busy  = busy;
            p_idle  = tx_idle;
            p_txreq = tx_req;
        end
    end

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (n < budget && !(all_empty() && !busy)) begin
            @(negedge clk);
            n++;
        end
        check(all_empty() && !busy, name, n, budget);
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] g, input string name);
        int n;
        n = 0;
        while (grant != g && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(grant == g, name, int'(grant), int'(g));
    endtask

    task automatic wait_txreq(input logic [NREQ-1:0] g, input string name);
        int n;
        n = 0;
        while (!(tx_req && grant == g) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tx_req && grant == g, name, int'(grant), int'(g));
    endtask

    task automatic check_log(input string name);
        check(grant_log.size() == exp_log.size(), name, grant_log.size(), exp_log.size());
        for (int k = 0; k < exp_log.size() && k < grant_log.size(); k++)
            check(grant_log[k] == exp_log[k], name, grant_log[k], exp_log[k]);
    endtask

    int r_sel, r_len;

    initial begin
        #1 rst_ = 1'b0;
        repeat (3) @(negedge clk);
        check(grant == '0, "rst_grant", int'(grant), 0);
        check(tx_req == 1'b0, "rst_tx_req", int'(tx_req), 0);
        check(tx_byte == 8'h00, "rst_tx_byte", int'(tx_byte), 0);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        check(req_ready == '0, "rst_req_ready", int'(req_ready), 0);
        #2 rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin from reset: two single-byte packets per requester.
        grant_log.delete();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < NREQ; r++) push_byte(r, 8'($urandom), 1'b1);
        wait_drain(2000, "rr_drain");
        exp_log.delete();
        for (int k = 0; k < 2 * NREQ; k++) exp_log.push_back(k % NREQ);
        check_log("rr_order");

        // Single packet from requester 1, including arbitration-to-tx_req latency.
        grant_log.delete();
        push_byte(1, 8'h55, 1'b0);
        push_byte(1, 8'hA3, 1'b1);
        wait_grant(4'b0010, "single_grant");
        @(negedge clk);
        check(tx_req == 1'b1, "first_txreq_latency", int'(tx_req), 1);
        wait_drain(500, "single_drain");
        exp_log = '{1};
        check_log("single_order");

        // Burst cap: requester 2 is cut after MAX_BURST bytes, requester 3 goes next.
        grant_log.delete();
        for (int b = 0; b < 6; b++) push_byte(2, 8'(8'h20 + b), b == 5);
        wait_grant(4'b0100, "burst_grant");
        push_byte(3, 8'hC0, 1'b0);
        push_byte(3, 8'hC1, 1'b1);
        wait_drain(2000, "burst_drain");
        exp_log = '{2, 3, 2};
        check_log("burst_order");

        // Stall: requester 0 drops valid for 50 cycles mid-packet.
        grant_log.delete();
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        wait_txreq(4'b0001, "stall_first");
        hold[0] = 1'b1;
        repeat (50) begin
            @(negedge clk);
            check(!tx_req, "stall_no_txreq", int'(tx_req), 0);
            check(grant == 4'b0001, "stall_grant", int'(grant), 1);
        end
        check(req_ready == 4'b0001, "stall_ready", int'(req_ready), 1);
        hold[0] = 1'b0;
        @(negedge clk);
        check(!tx_req, "stall_resume_early", int'(tx_req), 0);
        @(negedge clk);
        check(tx_req, "stall_resume", int'(tx_req), 1);
        wait_drain(1000, "stall_drain");

        // UART not idle while in ARB: no grant may be issued.
        grant_log.delete();
        @(posedge clk);
        #1 block = 1'b1;
        push_byte(3, 8'h7E, 1'b1);
        repeat (20) @(negedge clk);
        check(grant == '0, "blocked_grant", int'(grant), 0);
        check(!busy, "blocked_busy", int'(busy), 0);
        @(posedge clk);
        #1 block = 1'b0;
        wait_drain(500, "blocked_drain");
        exp_log = '{3};
        check_log("blocked_order");

        // Asynchronous reset while the first byte is in flight.
        push_byte(1, 8'h81, 1'b0);
        push_byte(1, 8'h82, 1'b0);
        push_byte(1, 8'h83, 1'b1);
        wait_txreq(4'b0010, "mid_first");
        @(negedge clk);
        check(busy, "mid_pre_busy", int'(busy), 1);
        rst_ = 1'b0;
        #1;
        check(grant == '0, "mid_rst_grant", int'(grant), 0);
        check(tx_req == 1'b0, "mid_rst_tx_req", int'(tx_req), 0);
        check(busy == 1'b0, "mid_rst_busy", int'(busy), 0);
        check(req_ready == '0, "mid_rst_ready", int'(req_ready), 0);
        check(tx_byte == 8'h00, "mid_rst_tx_byte", int'(tx_byte), 0);
        src_q[1].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        #2 rst_ = 1'b1;
        grant_log.delete();
        push_byte(2, 8'h5A, 1'b1);
        push_byte(0, 8'hC3, 1'b0);
        push_byte(0, 8'h3C, 1'b1);
        wait_drain(1000, "post_rst_drain");
        exp_log = '{0, 2};
        check_log("post_rst_order");

        // Random traffic with valid gaps and random frame lengths.
        rnd_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            r_sel = $urandom_range(0, NREQ - 1);
            r_len = $urandom_range(1, 6);
            for (int b = 0; b < r_len; b++) push_byte(r_sel, 8'($urandom), b == r_len - 1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        wait_drain(20000, "random_drain");
        rnd_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart` transmitter between `NREQ` byte-stream requesters (debug console, register-dump engine, loopback echo, etc.). Each requester offers bytes on a valid/ready handshake with a `last` marker. The arbiter grants one requester for a whole packet, capped at `MAX_BURST` bytes. It sequences each byte into the UART's `tx_byte`/`tx_req`/`tx_idle` interface and sits directly between the requesters and the `uart` instance in the top level.

## Interface
- `NREQ`, 4, number of requesters; allowed range 2..16.
- `MAX_BURST`, 16, maximum bytes per grant before forced re-arbitration; must be ≥1. Burst counter width is `$clog2(MAX_BURST+1)`.

Ports:
- `clk`  in  1  single clock, shared with `uart`.
- `rst_`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a byte on `req_data[8*i+:8]`.
- `req_data`  in  8*NREQ  byte lanes, packed by requester index.
- `req_last`  in  NREQ  the offered byte is the last byte of requester i's packet.
- `req_ready`  out  NREQ  the arbiter takes requester i's byte this cycle.
- `grant`  out  NREQ  one-hot current owner; all zero when no requester owns the UART.
- `busy`  out  1  high in every state except ARB.
- `tx_byte`  out  8  to `uart.tx_byte`.
- `tx_req`  out  1  to `uart.tx_req`; a registered single-cycle pulse.
- `tx_idle`  in  1  from `uart.tx_idle`.

## Operation
- FSM states are ARB, TAKE, ISSUE, BUSY and WAIT. On reset: state=ARB, `grant`=0, `tx_req`=0, `tx_byte`=0, `ptr`=NREQ-1, `cnt`=0, `lastf`=0. `req_ready`=0 and `busy`=0 follow from the state.
- **ARB:** acts only when `tx_idle`=1 and `|req_valid`. It selects the first index with `req_valid` set, searching upward from `ptr+1` modulo NREQ. It then registers the one-hot `grant`, clears `cnt` and moves to TAKE.
- **TAKE:** `req_ready[g]`=1. This signal is combinational from the state and `grant` only, never from `req_valid`. A transfer occurs on the edge where `req_valid[g]`=1; on that edge:
  - `tx_byte` <= `req_data[g]`
  - `tx_req` <= 1
  - `lastf` <= `req_last[g]` | (`cnt`==MAX_BURST-1)
  - next state is ISSUE.
- If `req_valid[g]`=0, the FSM stays in TAKE and keeps the grant. Requesters must not drop valid mid-packet for long.
- **ISSUE:** one cycle. `tx_req`=1 is visible here and the UART accepts it at the closing edge. That edge clears `tx_req` and moves to BUSY.
- **BUSY:** waits for `tx_idle`=0, which the UART produces in the first BUSY cycle, then moves to WAIT.
- **WAIT:** waits for `tx_idle`=1, then:
  - If `lastf`=1: `ptr` <= index(`grant`), `grant` <= 0, next state ARB.
  - Else: `cnt` <= `cnt`+1, next state TAKE.
- `req_last` is sampled only together with the transferred byte.
- Round-robin: after an owner releases, it has the lowest priority in the next search.
- Burst cap: after MAX_BURST bytes the grant is released even without `last`. The remainder of that packet competes again in ARB.
- `tx_byte` holds its value between transfers.

## Timing
- Arbitration to first `tx_req` takes 2 edges: ARB edge sets the grant, TAKE edge pulses `tx_req`.
- `tx_req` is high for exactly one cycle per byte, and only when the UART is idle. It is never re-asserted until `tx_idle` has gone low and then high again.
- Per-byte overhead beyond the UART frame is 3 cycles (WAIT→TAKE→ISSUE), provided `req_valid` is already high.
- Simultaneous requests in ARB: only one grant is issued. Requests arriving in any non-ARB state wait; there is no preemption.
- `tx_idle`=0 in ARB (UART driven elsewhere, or a frame still finishing): no grant is issued.
- Asynchronous reset mid-packet: all state returns to reset values immediately. `tx_req` drops and the partial packet is discarded.

## Test plan
- **Single packet:** requester 1 sends 0x55, 0xA3 (`last`). Expect `grant`=0010, two `tx_req` pulses, `tx_byte` of 0x55 then 0xA3, and a return to ARB with `ptr`=1.
- **Round-robin:** all four `req_valid` held high, each packet 1 byte with `last`. Grant order is 0,1,2,3,0; no requester is granted twice in a row.
- **Burst cap:** MAX_BURST=4; requester 2 sends 6 bytes with `last` only on byte 6 while requester 3 is waiting. Expect 4 bytes from requester 2, then requester 3's packet, then requester 2's remaining 2 bytes.
- **Stall:** granted requester drops `req_valid` for 50 cycles mid-packet. Expect the grant held, `tx_req`=0 throughout, and resumption on the first cycle valid returns.
- **Handshake check:** with the real `uart` (CLK_HZ/BAUD=16), assert `tx_req` occurs only when `tx_idle`=1. Assert exactly one 1-cycle pulse per frame, and that the serial `txd` bytes match the sequence offered.
- **Reset mid-frame:** pull `rst_` low during BUSY. Expect `grant`=0, `tx_req`=0, `busy`=0 asynchronously, and a clean packet after release.
